// File: rtl/spike_dispatcher.sv
// -----------------------------------------------------------------------------
// spike_dispatcher
//
// Transmit side of the spike interface. At the end of each timestep it latches
// the fire flags of a local neuron group. It then serialises them as source
// addresses over a valid/ready link, one address per accepted transfer, lowest
// neuron index first.
//
// Ports:
//   clk_i            single clock, rising-edge
//   rst_i            asynchronous, active-high reset
//   base_address_i   address of neuron 0 of the group, sampled at accept
//   fire_vector_i    bit i = neuron i fired this timestep
//   fire_valid_i     one-cycle strobe at timestep end, presents fire_vector_i
//   spike_addr_o     source address of the spike currently offered
//   spike_valid_o    spike_addr_o is valid
//   spike_ready_i    downstream accepts the offered spike
//   busy_o           a batch is in progress (SEND or DONE)
//   batch_done_o     one-cycle pulse when a batch has fully drained
//   overrun_o        one-cycle pulse after a fire_valid_i seen while busy
//   sent_count_o     spikes sent in the current/last batch
// -----------------------------------------------------------------------------
module spike_dispatcher #(
  parameter int NUM_NEURONS = 5,
  parameter int ADDR_W      = 12,
  parameter int CNT_W       = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_W-1:0]      base_address_i,
  input  logic [NUM_NEURONS-1:0] fire_vector_i,
  input  logic                   fire_valid_i,
  output logic [ADDR_W-1:0]      spike_addr_o,
  output logic                   spike_valid_o,
  input  logic                   spike_ready_i,
  output logic                   busy_o,
  output logic                   batch_done_o,
  output logic                   overrun_o,
  output logic [CNT_W-1:0]       sent_count_o
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q,      state_d;
  logic [NUM_NEURONS-1:0] pending_q,    pending_d;
  logic [ADDR_W-1:0]      base_q,       base_d;
  logic [CNT_W-1:0]       sent_count_q, sent_count_d;
  logic                   overrun_q,    overrun_d;

  logic [IDX_W-1:0]       low_idx;
  logic [NUM_NEURONS-1:0] pending_rest;
  logic                   xfer;

  // Priority encoder: index of the lowest set pending bit. Scanning from the
  // top down lets the last (lowest) hit win without a break.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // x & (x-1) clears exactly the lowest set bit, i.e. the one being sent.
  assign pending_rest = pending_q & (pending_q - NUM_NEURONS'(1));

  // Valid depends only on state, so the transfer term is ready gated by state.
  assign xfer = (state_q == SEND) && spike_ready_i;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    base_d       = base_q;
    sent_count_d = sent_count_q;
    overrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire_valid_i) begin
          pending_d    = fire_vector_i;
          base_d       = base_address_i;
          sent_count_d = '0;
          // An empty batch still goes through DONE so batch_done pulses.
          state_d      = (|fire_vector_i) ? SEND : DONE;
        end
      end

      SEND: begin
        // A strobe while busy is dropped, even on the final transfer.
        overrun_d = fire_valid_i;
        if (xfer) begin
          pending_d    = pending_rest;
          sent_count_d = sent_count_q + CNT_W'(1);
          if (pending_rest == '0) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        overrun_d = fire_valid_i;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      base_q       <= '0;
      sent_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      base_q       <= base_d;
      sent_count_q <= sent_count_d;
      overrun_q    <= overrun_d;
    end
  end

  // Outputs come from registered state only, so the address stays stable
  // under backpressure and there is no combinational path from ready.
  always_comb begin
    spike_valid_o = 1'b0;
    spike_addr_o  = '0;
    if (state_q == SEND) begin
      spike_valid_o = 1'b1;
      // Modulo 2^ADDR_W addition: the address wraps with no carry out.
      spike_addr_o  = base_q + ADDR_W'(low_idx);
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign batch_done_o = (state_q == DONE);
  assign overrun_o    = overrun_q;
  assign sent_count_o = sent_count_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
module tb_spike_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] base_address = '0;
  logic [4:0]  fire_vector = '0;
  logic        fire_valid = 1'b0;
  logic        spike_ready = 1'b0;
  logic [11:0] spike_addr;
  logic        spike_valid;
  logic        busy;
  logic        batch_done;
  logic        overrun;
  logic [5:0]  sent_count;

  int checks = 0;
  int errors = 0;

  spike_dispatcher #(
    .NUM_NEURONS(5),
    .ADDR_W(12),
    .CNT_W(6)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .base_address_i(base_address),
    .fire_vector_i(fire_vector),
    .fire_valid_i(fire_valid),
    .spike_addr_o(spike_addr),
    .spike_valid_o(spike_valid),
    .spike_ready_i(spike_ready),
    .busy_o(busy),
    .batch_done_o(batch_done),
    .overrun_o(overrun),
    .sent_count_o(sent_count)
  );

  always #5 clk = ~clk;

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (spike_valid !== 1'b0 || spike_addr !== 12'h000 || busy !== 1'b0 ||
        batch_done !== 1'b0 || overrun !== 1'b0 || sent_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b addr=%h busy=%b done=%b ovr=%b cnt=%0d required all 0",
               spike_valid, spike_addr, busy, batch_done, overrun, sent_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b required 0 0", busy, spike_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [11:0] exp [3];
    exp[0] = 12'h101; exp[1] = 12'h102; exp[2] = 12'h104;
    base_address = 12'h100; fire_vector = 5'b10110; fire_valid = 1'b1; spike_ready = 1'b1;
    @(negedge clk);
    fire_valid = 1'b0; base_address = 12'h7AA; fire_vector = 5'b01001;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (spike_valid !== 1'b1 || spike_addr !== exp[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_spike%0d: got valid=%b addr=%h busy=%b required valid=1 addr=%h busy=1",
                 i, spike_valid, spike_addr, busy, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (batch_done !== 1'b1 || spike_valid !== 1'b0 || sent_count !== 6'd3) begin
      errors++;
      $display("FAIL basic_done: got done=%b valid=%b cnt=%0d required done=1 valid=0 cnt=3",
               batch_done, spike_valid, sent_count);
    end
    @(negedge clk);
    checks++;
    if (batch_done !== 1'b0 || busy !== 1'b0 || sent_count !== 6'd3) begin
      errors++;
      $display("FAIL basic_idle: got done=%b busy=%b cnt=%0d required done=0 busy=0 cnt=3",
               batch_done, busy, sent_count);
    end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    base_address = 12'h100; fire_vector = 5'b10110; fire_valid = 1'b1; spike_ready = 1'b1;
    @(negedge clk);
    fire_valid = 1'b0;
    checks++;
    if (spike_valid !== 1'b1 || spike_addr !== 12'h101) begin
      errors++;
      $display("FAIL bp_first: got valid=%b addr=%h required valid=1 addr=101", spike_valid, spike_addr);
    end
    @(negedge clk);
    spike_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (spike_valid !== 1'b1 || spike_addr !== 12'h102 || sent_count !== 6'd1) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b addr=%h cnt=%0d required valid=1 addr=102 cnt=1",
                 j, spike_valid, spike_addr, sent_count);
      end
      @(negedge clk);
    end
    checks++;
    if (spike_valid !== 1'b1 || spike_addr !== 12'h102) begin
      errors++;
      $display("FAIL bp_release: got valid=%b addr=%h required valid=1 addr=102", spike_valid, spike_addr);
    end
    spike_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (spike_valid !== 1'b1 || spike_addr !== 12'h104) begin
      errors++;
      $display("FAIL bp_third: got valid=%b addr=%h required valid=1 addr=104", spike_valid, spike_addr);
    end
    @(negedge clk);
    checks++;
    if (batch_done !== 1'b1 || spike_valid !== 1'b0 || sent_count !== 6'd3) begin
      errors++;
      $display("FAIL bp_done: got done=%b valid=%b cnt=%0d required done=1 valid=0 cnt=3",
               batch_done, spike_valid, sent_count);
    end
    @(negedge clk);
    $display("test_backpressure done");
  endtask

  task automatic test_empty();
    base_address = 12'h050; fire_vector = 5'b00000; fire_valid = 1'b1; spike_ready = 1'b1;
    @(negedge clk);
    fire_valid = 1'b0;
    checks++;
    if (spike_valid !== 1'b0 || batch_done !== 1'b1 || sent_count !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_done: got valid=%b done=%b cnt=%0d busy=%b required valid=0 done=1 cnt=0 busy=1",
               spike_valid, batch_done, sent_count, busy);
    end
    @(negedge clk);
    checks++;
    if (spike_valid !== 1'b0 || batch_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: got valid=%b done=%b busy=%b required 0 0 0", spike_valid, batch_done, busy);
    end
    $display("test_empty done");
  endtask

  task automatic test_wrap();
    logic [11:0] exp [5];
    exp[0] = 12'hFFE; exp[1] = 12'hFFF; exp[2] = 12'h000; exp[3] = 12'h001; exp[4] = 12'h002;
    base_address = 12'hFFE; fire_vector = 5'b11111; fire_valid = 1'b1; spike_ready = 1'b1;
    @(negedge clk);
    fire_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (spike_valid !== 1'b1 || spike_addr !== exp[i]) begin
        errors++;
        $display("FAIL wrap_spike%0d: got valid=%b addr=%h required valid=1 addr=%h",
                 i, spike_valid, spike_addr, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (batch_done !== 1'b1 || sent_count !== 6'd5) begin
      errors++;
      $display("FAIL wrap_done: got done=%b cnt=%0d required done=1 cnt=5", batch_done, sent_count);
    end
    @(negedge clk);
    $display("test_wrap done");
  endtask

  task automatic test_overrun();
    base_address = 12'h100; fire_vector = 5'b10110; fire_valid = 1'b1; spike_ready = 1'b1;
    @(negedge clk);
    // Second strobe during the batch, on the first transfer edge.
    fire_valid = 1'b1; fire_vector = 5'b00001; base_address = 12'h300;
    checks++;
    if (spike_addr !== 12'h101 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got addr=%h ovr=%b required addr=101 ovr=0", spike_addr, overrun);
    end
    @(negedge clk);
    fire_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || spike_addr !== 12'h102 || spike_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: got ovr=%b addr=%h valid=%b required ovr=1 addr=102 valid=1",
               overrun, spike_addr, spike_valid);
    end
    @(negedge clk);
    // Strobe coincident with the final transfer is also an overrun.
    fire_valid = 1'b1;
    checks++;
    if (overrun !== 1'b0 || spike_addr !== 12'h104) begin
      errors++;
      $display("FAIL ovr_once: got ovr=%b addr=%h required ovr=0 addr=104", overrun, spike_addr);
    end
    @(negedge clk);
    fire_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || batch_done !== 1'b1 || sent_count !== 6'd3 || spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_final: got ovr=%b done=%b cnt=%0d valid=%b required ovr=1 done=1 cnt=3 valid=0",
               overrun, batch_done, sent_count, spike_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || spike_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_dropped: got busy=%b valid=%b ovr=%b required 0 0 0", busy, spike_valid, overrun);
    end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid_batch();
    base_address = 12'h100; fire_vector = 5'b10110; fire_valid = 1'b1; spike_ready = 1'b1;
    @(negedge clk);
    fire_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (spike_addr !== 12'h102 || sent_count !== 6'd1) begin
      errors++;
      $display("FAIL rstmid_pre: got addr=%h cnt=%0d required addr=102 cnt=1", spike_addr, sent_count);
    end
    spike_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (spike_valid !== 1'b0 || spike_addr !== 12'h000 || busy !== 1'b0 ||
        batch_done !== 1'b0 || overrun !== 1'b0 || sent_count !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_async: got valid=%b addr=%h busy=%b done=%b ovr=%b cnt=%0d required all 0",
               spike_valid, spike_addr, busy, batch_done, overrun, sent_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base_address = 12'h200; fire_vector = 5'b00001; fire_valid = 1'b1; spike_ready = 1'b1;
    @(negedge clk);
    fire_valid = 1'b0;
    checks++;
    if (spike_valid !== 1'b1 || spike_addr !== 12'h200) begin
      errors++;
      $display("FAIL rstmid_new: got valid=%b addr=%h required valid=1 addr=200", spike_valid, spike_addr);
    end
    @(negedge clk);
    checks++;
    if (spike_valid !== 1'b0 || batch_done !== 1'b1 || sent_count !== 6'd1) begin
      errors++;
      $display("FAIL rstmid_done: got valid=%b done=%b cnt=%0d required valid=0 done=1 cnt=1",
               spike_valid, batch_done, sent_count);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got busy=%b valid=%b required 0 0", busy, spike_valid);
    end
    $display("test_reset_mid_batch done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_wrap();
    test_overrun();
    test_reset_mid_batch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_dispatcher.md
Name: spike_dispatcher

Overview:
- Transmit side of the spike interface that the synapse MAC consumes.
- At the end of each timestep, latches the fire flags of a local neuron group.
- Serialises them as 12-bit source addresses over a valid/ready link, one address per accepted transfer, lowest neuron index first.
- Sits between the neuron potential/threshold units and the NoC injection port, which fans spikes out to downstream MACs.

Parameters:
- NUM_NEURONS, 5, neurons in the group; width of the fire vector (2..32).
- ADDR_W, 12, source address width; matches the MAC source_address port.
- CNT_W, 6, width of the sent-spike counter; must satisfy 2^CNT_W > NUM_NEURONS.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- base_address  in  ADDR_W  address of neuron 0 of the group; sampled at accept.
- fire_vector  in  NUM_NEURONS  bit i = neuron i fired this timestep.
- fire_valid  in  1  one-cycle strobe at timestep end; presents fire_vector.
- spike_addr  out  ADDR_W  source address of the spike currently offered.
- spike_valid  out  1  spike_addr is valid.
- spike_ready  in  1  downstream accepts the offered spike.
- busy  out  1  a batch is in progress (state != IDLE).
- batch_done  out  1  one-cycle pulse when a batch has fully drained.
- overrun  out  1  one-cycle pulse when fire_valid arrives while busy.
- sent_count  out  CNT_W  spikes sent in the current/last batch.

Behaviour:
- State: pending[NUM_NEURONS], base_q[ADDR_W], sent_count, FSM {IDLE, SEND, DONE}.
- RESET asserted (async), at any time including mid-batch:
  - state=IDLE, pending=0, base_q=0, sent_count=0.
  - spike_valid=0, spike_addr=0, busy=0, batch_done=0, overrun=0.
  - Any in-flight spike is abandoned, not completed.
- Accept (state IDLE, fire_valid=1 at an edge):
  - pending<=fire_vector, base_q<=base_address, sent_count<=0.
  - Next state is SEND if fire_vector!=0, else DONE (an empty batch still produces batch_done).
- SEND outputs:
  - spike_valid=1.
  - spike_addr=base_q + index of lowest set bit of pending, modulo 2^ADDR_W (wraps; no carry out).
  - Both are driven combinationally from registered state only; no path from spike_ready.
  - Latency: fire_valid at edge k gives spike_valid high in the cycle after edge k.
- Handshake:
  - A transfer occurs at an edge where spike_valid=1 and spike_ready=1.
  - On a transfer: clear that pending bit and increment sent_count.
  - If the cleared bit was the last set bit, go to DONE; otherwise stay in SEND, and the next address is offered the following cycle.
  - Sustained throughput is one spike per cycle while ready is held high.
  - While spike_valid=1 and spike_ready=0, spike_addr must hold stable and spike_valid must not drop.
- DONE: batch_done=1 for exactly one cycle, spike_valid=0, then IDLE. sent_count holds its value until the next accept.
- busy=1 in SEND and DONE.
- overrun:
  - fire_valid in SEND or DONE is ignored: pending is unchanged and the vector is dropped.
  - overrun pulses high for the cycle after that edge.
  - fire_valid in the same cycle as the final transfer is also an overrun. The IDLE-only accept rule has no exceptions.
- Changes to base_address or fire_vector outside an accept edge have no effect.
- spike_ready while spike_valid=0 is ignored.

Test Plan:
- Basic batch: base=0x100, vector=5'b10110, ready held 1 → addresses 0x101, 0x102, 0x104 on three consecutive cycles starting the cycle after the strobe. batch_done pulses the following cycle; sent_count=3.
- Backpressure: same batch with ready low for 4 cycles on the second spike → spike_addr stays 0x102 with valid high for all 4 cycles; no spike lost or duplicated; sent_count=3.
- Empty batch: vector=0 → spike_valid never rises; batch_done pulses the cycle after the strobe; sent_count=0.
- Wrap: base=0xFFE, vector=5'b11111 → addresses 0xFFE, 0xFFF, 0x000, 0x001, 0x002.
- Overrun: second strobe (vector=5'b00001) during the first batch → overrun pulses once; output sequence equals the first batch only.
- Reset mid-batch: assert RESET asynchronously (between edges) after the first of 3 spikes → all outputs 0 immediately. A new strobe after release (base=0x200, vector=5'b00001) emits only 0x200.
